// File: rtl/zynet_pkg.sv
// Shared definitions for the zyNet output path: default vector geometry,
// class-index width derivation and the serializer FSM encoding.
package zynet_pkg;

    localparam int WORD_SIZE_DEF   = 16;
    localparam int OUTPUT_SIZE_DEF = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    function automatic int class_width(input int output_size);
        return (output_size > 1) ? $clog2(output_size) : 1;
    endfunction

endpackage

// File: rtl/zynet_argmax_tracker.sv
// Running signed argmax over the words of one vector as they are handshaked out.
// arg_next_o is the argmax including the word being accepted this cycle.
module zynet_argmax_tracker
    import zynet_pkg::*;
#(
    parameter int  WORD_SIZE   = WORD_SIZE_DEF,
    parameter int  OUTPUT_SIZE = OUTPUT_SIZE_DEF,
    localparam int CLASS_W     = class_width(OUTPUT_SIZE)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    input  logic                        first_i,
    input  logic signed [WORD_SIZE-1:0] word_i,
    input  logic [CLASS_W-1:0]          index_i,
    output logic [CLASS_W-1:0]          arg_next_o
);

    logic signed [WORD_SIZE-1:0] max_q, max_d;
    logic [CLASS_W-1:0]          arg_q, arg_d;

    // Words arrive in ascending index order, so a strict compare keeps the
    // lowest index among equal maxima.
    // NOTE: every always_comb output is given its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        max_d = max_q;
        arg_d = arg_q;
        if (en_i && (first_i || (word_i > max_q))) begin
            max_d = word_i;
            arg_d = index_i;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= max_d;
            arg_q <= arg_d;
        end
    end

    assign arg_next_o = arg_d;

endmodule

// File: rtl/zynet_output_serializer.sv
// Takes one result vector from zyNet via valid/yumi, streams it one word per
// ready/valid beat, and strobes the argmax class the cycle after the last beat.
module zynet_output_serializer
    import zynet_pkg::*;
#(
    parameter int  WORD_SIZE   = WORD_SIZE_DEF,
    parameter int  OUTPUT_SIZE = OUTPUT_SIZE_DEF,
    localparam int CLASS_W     = class_width(OUTPUT_SIZE)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] vec_i,
    input  logic                             vec_valid_i,
    output logic                             vec_yumi_o,
    output logic [WORD_SIZE-1:0]             data_o,
    output logic                             valid_o,
    output logic                             last_o,
    input  logic                             ready_i,
    output logic [CLASS_W-1:0]               class_o,
    output logic                             class_valid_o
);

    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(OUTPUT_SIZE - 1);

    ser_state_e                            state_q, state_d;
    logic [CLASS_W-1:0]                    index_q;
    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] buf_q;
    logic [CLASS_W-1:0]                    class_q;
    logic                                  class_valid_q;
    logic [CLASS_W-1:0]                    arg_next;
    logic                                  yumi;
    logic                                  handshake;
    logic                                  is_last;

    assign is_last   = (state_q == ST_SEND) && (index_q == LAST_IDX);
    assign handshake = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        yumi    = 1'b0;
        valid_o = 1'b0;
        data_o  = '0;
        case (state_q)
            ST_IDLE: begin
                yumi = vec_valid_i && !reset_i;
                if (yumi) state_d = ST_SEND;
            end
            ST_SEND: begin
                valid_o = 1'b1;
                data_o  = buf_q[index_q];
                if (ready_i && is_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The index is left at the last word on the final beat; yumi reloads it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            // NOTE: the vector buffer is cleared on reset so a discarded vector can never resurface on data_o.
            buf_q         <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            class_valid_q <= handshake && is_last;
            if (yumi) begin
                buf_q   <= vec_i;
                index_q <= '0;
            end else if (handshake && !is_last) begin
                index_q <= index_q + 1'b1;
            end
            if (handshake && is_last) class_q <= arg_next;
        end
    end

    zynet_argmax_tracker #(
        .WORD_SIZE  (WORD_SIZE),
        .OUTPUT_SIZE(OUTPUT_SIZE)
    ) u_argmax (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .en_i      (handshake),
        .first_i   (index_q == '0),
        .word_i    ($signed(data_o)),
        .index_i   (index_q),
        .arg_next_o(arg_next)
    );

    assign vec_yumi_o    = yumi;
    assign last_o        = is_last;
    assign class_o       = class_q;
    assign class_valid_o = class_valid_q;

endmodule

// File: doc/zynet_output_serializer.md
Name: zynet_output_serializer

Overview:
- Consumer at the far end of the zyNet output interface: accepts one OUTPUT_SIZE-word result vector per inference using the valid/yumi handshake.
- Streams the vector out one word per beat on a ready/valid interface, toward the host-side FIFO/UART path.
- Computes the argmax class index alongside the stream and reports it with a one-cycle strobe after the final word.

Parameters:
- WORD_SIZE, 16, width of one signed two's-complement output word.
- OUTPUT_SIZE, 10, words per result vector; must be >= 2.
- CLASS_W, $clog2(OUTPUT_SIZE), localparam; width of the class index.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- vec_i  in  OUTPUT_SIZE*WORD_SIZE  result vector; word k = vec_i[k*WORD_SIZE +: WORD_SIZE].
- vec_valid_i  in  1  vector present from zyNet.
- vec_yumi_o  out  1  vector consumed this cycle; combinational.
- data_o  out  WORD_SIZE  current serialized word.
- valid_o  out  1  data_o is valid.
- last_o  out  1  data_o is word OUTPUT_SIZE-1; qualified by valid_o.
- ready_i  in  1  downstream accepts data_o.
- class_o  out  CLASS_W  argmax index of the last completed vector.
- class_valid_o  out  1  one-cycle strobe; class_o was updated this cycle.

Behaviour:
- Reset: state IDLE; vec_yumi_o=0, valid_o=0, last_o=0, data_o=0, class_o=0, class_valid_o=0; index, max register and vector buffer cleared.
- Reset mid-SEND discards the buffered vector. No class strobe is issued for the discarded vector.
- Two-state FSM: IDLE and SEND.
- IDLE:
  - vec_yumi_o = vec_valid_i. This is the only cycle yumi can be high; it never depends on ready_i.
  - On yumi: latch vec_i into the buffer, index<=0, move to SEND.
- SEND:
  - valid_o=1 and data_o=buffer word[index]; both registered/muxed from the buffer, never from vec_i.
  - last_o = (index==OUTPUT_SIZE-1).
  - Handshake occurs when valid_o & ready_i. On a handshake, index increments.
  - data_o is held stable while ready_i=0. valid_o never drops before the handshake.
- Argmax:
  - On the handshake of word 0, max<=word0 and arg<=0.
  - On each later handshake, if word > max (signed strict compare), update max and arg. Ties keep the lower index.
- Final beat: the handshake with last_o=1 moves the FSM to IDLE. On the next cycle, class_o<=final arg (including word k of the final beat) and class_valid_o=1 for exactly that cycle.
- class_o holds its value until the next completed vector.
- Latency:
  - yumi in cycle T gives word0 valid in T+1.
  - With ready_i held high, words occupy T+1..T+OUTPUT_SIZE; class strobe at T+OUTPUT_SIZE+1.
- Back-to-back vectors: the next yumi can be issued no earlier than the cycle after the final handshake, i.e. in the same cycle as the class strobe. That gives a one-cycle bubble between vectors.
- vec_valid_i high during SEND is ignored (no yumi, nothing latched). zyNet holds its data until consumed.
- Index wrap: index never exceeds OUTPUT_SIZE-1. The counter is not updated on the final handshake (it reloads on yumi).

Decomposition:
- Shared package (zynet_pkg): WORD_SIZE and OUTPUT_SIZE defaults, CLASS_W derivation, FSM state encoding.
- One sub-module, zynet_argmax_tracker: takes word, index, a first flag and an enable; holds max/arg, and performs the signed compare with ties to the lower index.
- FSM, buffer and output mux stay in the top module.

Test Plan:
- Reset, then vector words 0..9 = 5,-3,100,7,100,-32768,0,99,1,2, ready_i=1 → yumi for 1 cycle; 10 beats in order with last_o only on beat 9; class_o=2 (tie resolved low) with strobe one cycle after beat 9.
- Same vector, ready_i toggled 1,0,0,1 pattern → data_o/valid_o stable during stalls; exactly 10 handshakes; class_o=2.
- All words = -1 except word 9 = 0 → class_o=9; all words equal -32768 → class_o=0.
- vec_valid_i held high continuously with two different vectors → yumi only in IDLE cycles; second vector word0 appears 2 cycles after the first vector's final handshake; class strobes=2.
- reset_i asserted during beat 4 → next cycle valid_o=0, class_valid_o=0, class_o=0; the next vector streams from word 0 correctly.
- vec_valid_i pulsed during SEND → no yumi, buffer unchanged, outputs match the original vector.
